mesm6_alu_arb: RTL and testbench
================================

# mesm6_alu_arb

Two-port arbiter and sequencer for the shared mesm6 ALU. It accepts operation requests from the instruction-execution unit (port 0) and an auxiliary requester (port 1, e.g. address/interrupt logic). It grants one request at a time, round-robin, and holds opcode and operands stable for the whole multicycle operation. It enforces the ALU's mandatory NOP gap between operations and returns result/Y with requester tag. A watchdog converts an operation that never signals done (unimplemented opcodes) into an error response.

## Interface
Parameters:
- TIMEOUT, default 32: maximum BUSY cycles to wait for `alu_done` before an error response; legal range 2..255.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- req_valid  in  [1:0]  request pending per port; held with op/a/b until accepted
- req_ready  out  [1:0]  combinational one-hot accept, only in IDLE; request transfers when valid&ready
- req_op  in  [1:0][`ALU_OP_WIDTH-1:0]  opcode per port
- req_a, req_b  in  [1:0][47:0]  operands per port
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  port the response belongs to
- rsp_result, rsp_y  out  48 each  ALU result and least-significant word
- rsp_err  out  1  timeout; result/y are 0 when set
- busy  out  1  high in BUSY
- alu_op  out  `ALU_OP_WIDTH  registered opcode to ALU
- alu_a, alu_b  out  48 each  registered operands to ALU
- alu_done, alu_result, alu_y  in  1/48/48  ALU status and outputs

## Operation
- Reset values: alu_op=`ALU_NOP, alu_a=alu_b=0, rsp_valid=0, rsp_id=0, rsp_result=rsp_y=0, rsp_err=0, busy=0, state IDLE, timeout counter 0, last-grant=1 (port 0 wins first tie).
- IDLE: alu_op=NOP. `alu_done` is ignored. If any req_valid, grant one port:
  - single valid port wins;
  - both valid: the port not granted last wins;
  - last-grant updates on every accept.
- Accept of non-NOP op: latch op/a/b into alu_op/alu_a/alu_b, store id, clear counter, go to BUSY.
- Accept of `ALU_NOP: ALU is not touched; next cycle rsp_valid=1 with result=y=0, err=0; stay in IDLE.
- BUSY: req_ready=0; alu_* held constant.
  - alu_done=1: register rsp_result=alu_result, rsp_y=alu_y, err=0, rsp_valid=1 next cycle; alu_op←NOP; go to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without done: rsp_valid=1 with err=1 and result=y=0; alu_op←NOP; go to IDLE.
  - done and timeout in the same cycle: done wins.
- A NOP is presented to the ALU for ≥1 cycle between any two operations, guaranteed by the mandatory IDLE cycle. This clears the ALU's latched done.
- Reset mid-operation: in-flight op is discarded with no response. alu_op is NOP from the cycle after reset.
- rsp_* fields hold their value after the pulse, until the next response.

## Timing
- Accept in cycle N. alu_op valid N+1. ALU asserts done at end of N+1+(k−1) for a k-cycle op. Response pulse at N+k+2. Examples: AND/OR/XOR at N+3, ARX at N+4.
- Earliest next accept is in the response cycle, so back-to-back one-cycle ops complete every 3 cycles.
- Timeout response comes TIMEOUT+1 cycles after accept.
- NOP request: response at N+1; next accept is allowed at N+1.

## Structure
- `ALU_NOP and `ALU_OP_WIDTH come from mesm6_defines.sv.
- Add `ALU_ARB_PORTS (2) there.
- State enum {IDLE, BUSY} is local to the module.
- One sub-module: mesm6_rr_arb2, a combinational two-requester round-robin picker (inputs valid[1:0] and last; output one-hot grant).

## Test plan
- Port 0 AND, a=48'h0F0F, b=48'h00FF, accept N → rsp_valid at N+3, result 48'h000F, y 0, id 0, err 0; alu_op NOP at N+3.
- Port 1 ARX, a=48'hFFFF_FFFF_FFFF, b=1 → result 48'h1 (carry-around), y 0, id 1, response at N+4; alu_a/alu_b stable through BUSY.
- Both ports valid continuously with XOR ops → grants alternate 0,1,0,1, responses every 3 cycles, at least one NOP cycle on alu_op between ops.
- TIMEOUT=8, port 0 op `ALU_FMUL (never done) → rsp_err=1, result=y=0 at N+9; following port 1 XOR a=5, b=3 → result 6, y 5.
- Reset asserted in the second BUSY cycle of ARX → no rsp_valid, alu_op NOP next cycle, all outputs at reset values; a subsequent port 0 AND completes normally.
- Port 1 request with `ALU_NOP → rsp_valid at N+1, zeros, id 1, alu_op never leaves NOP.

Source files
------------

// File: rtl/mesm6_alu_arb_pkg.sv
// mesm6_alu_arb_pkg
//   Shared constants and types for the mesm6 ALU arbiter: opcode width and
//   encodings, number of requesting ports, operand word type and the
//   registered response bundle.
package mesm6_alu_arb_pkg;

  localparam int ALU_OP_WIDTH  = 5;
  localparam int ALU_ARB_PORTS = 2;
  localparam int WORD_W        = 48;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP  = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ARX  = 5'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_FMUL = 5'd5;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic  id;
    logic  err;
    word_t result;
    word_t y;
  } rsp_t;

  // Response bundle for a request that never reaches the ALU or was abandoned.
  function automatic rsp_t rsp_empty(input logic id, input logic err);
    rsp_t r;
    r.id     = id;
    r.err    = err;
    r.result = '0;
    r.y      = '0;
    return r;
  endfunction

endpackage

// File: rtl/mesm6_alu_arb_rr_arb2.sv
// mesm6_rr_arb2
//   Combinational two-requester round-robin picker.
//   valid_i : request pending per requester
//   last_i  : requester granted most recently
//   grant_o : one-hot grant (all zero when nothing is valid)
module mesm6_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // contention: favour the requester that was not served last
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mesm6_alu_arb.sv
// mesm6_alu_arb
//   Arbiter/sequencer in front of the shared mesm6 ALU. Grants one of two
//   requesters round-robin, holds opcode/operands for the whole multicycle
//   operation, guarantees a NOP cycle between operations and returns the
//   result tagged with the requester. Operations that never finish are
//   turned into error responses by a watchdog.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     req_valid/req_ready        per-port handshake (ready only in IDLE)
//     req_op/req_a/req_b         per-port opcode and operands
//     rsp_valid/rsp_id           one-cycle response pulse and its port
//     rsp_result/rsp_y/rsp_err   response payload (held until next response)
//     busy                       operation in flight
//     alu_op/alu_a/alu_b         registered ALU inputs
//     alu_done/alu_result/alu_y  ALU status and outputs
//
//   state | meaning
//   IDLE  | ALU sees NOP; a request may be accepted
//   BUSY  | ALU inputs held; waiting for alu_done or watchdog expiry
module mesm6_alu_arb
  import mesm6_alu_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [ALU_ARB_PORTS-1:0]                      req_valid,
  output logic [ALU_ARB_PORTS-1:0]                      req_ready,
  input  logic [ALU_ARB_PORTS-1:0][ALU_OP_WIDTH-1:0]    req_op,
  input  logic [ALU_ARB_PORTS-1:0][WORD_W-1:0]          req_a,
  input  logic [ALU_ARB_PORTS-1:0][WORD_W-1:0]          req_b,
  output logic                                          rsp_valid,
  output logic                                          rsp_id,
  output logic [WORD_W-1:0]                             rsp_result,
  output logic [WORD_W-1:0]                             rsp_y,
  output logic                                          rsp_err,
  output logic                                          busy,
  output logic [ALU_OP_WIDTH-1:0]                       alu_op,
  output logic [WORD_W-1:0]                             alu_a,
  output logic [WORD_W-1:0]                             alu_b,
  input  logic                                          alu_done,
  input  logic [WORD_W-1:0]                             alu_result,
  input  logic [WORD_W-1:0]                             alu_y
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic                    last_q, last_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ALU_OP_WIDTH-1:0] op_q, op_d;
  word_t                   a_q, a_d, b_q, b_d;
  logic                    id_q, id_d;
  logic                    rsp_valid_q, rsp_valid_d;
  rsp_t                    rsp_q, rsp_d;

  logic [1:0] grant;
  logic       sel;

  mesm6_rr_arb2 u_rr (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign sel = grant[1];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    req_ready   = 2'b00;

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant != 2'b00) begin
          last_d = sel;
          if (req_op[sel] == ALU_NOP) begin
            // NOP never reaches the ALU; answer immediately with zeros
            rsp_valid_d = 1'b1;
            rsp_d       = rsp_empty(sel, 1'b0);
          end else begin
            op_d    = req_op[sel];
            a_d     = req_a[sel];
            b_d     = req_b[sel];
            id_d    = sel;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        if (alu_done) begin
          rsp_valid_d   = 1'b1;
          rsp_d.id      = id_q;
          rsp_d.err     = 1'b0;
          rsp_d.result  = alu_result;
          rsp_d.y       = alu_y;
          op_d          = ALU_NOP;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_d       = rsp_empty(id_q, 1'b1);
          op_d        = ALU_NOP;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      op_q        <= ALU_NOP;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= rsp_empty(1'b0, 1'b0);
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign busy       = (state_q == BUSY);
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_q.id;
  assign rsp_err    = rsp_q.err;
  assign rsp_result = rsp_q.result;
  assign rsp_y      = rsp_q.y;

endmodule

// File: tb/tb_mesm6_alu_arb.sv
module tb_mesm6_alu_arb;
  import mesm6_alu_arb_pkg::*;

  localparam int T  = 8;
  localparam int OW = ALU_OP_WIDTH;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid, req_ready;
  logic [1:0][OW-1:0]   req_op;
  logic [1:0][47:0]     req_a, req_b;
  logic                 rsp_valid, rsp_id, rsp_err, busy;
  logic [47:0]          rsp_result, rsp_y;
  logic [OW-1:0]        alu_op;
  logic [47:0]          alu_a, alu_b;
  logic                 alu_done;
  logic [47:0]          alu_result, alu_y;

  mesm6_alu_arb #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_y(alu_y)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // requester drive state
  logic               drv_reset = 1'b1;
  logic [1:0]         drv_valid = 2'b00;
  logic [1:0][OW-1:0] drv_op = '0;
  logic [1:0][47:0]   drv_a = '0, drv_b = '0;

  // bench ALU: ops presented during the previous cycle
  logic [OW-1:0] s_op = ALU_NOP;
  logic [47:0]   s_a = '0, s_b = '0;
  int            alu_cnt = 0;

  // reference model (transaction timeline)
  bit            chk_en = 0;
  bit            m_has_op = 0;
  int            m_end = 0;
  logic [OW-1:0] m_op = ALU_NOP;
  logic [47:0]   m_a = '0, m_b = '0;
  logic          m_last = 1'b1;
  bit            m_pend = 0;
  int            m_rsp_cyc = 0;
  logic          p_id = 0, p_err = 0;
  logic [47:0]   p_res = '0, p_y = '0;
  logic          h_id = 0, h_err = 0;
  logic [47:0]   h_res = '0, h_y = '0;

  // handshake observations
  bit   acc_seen [2];
  int   acc_cyc [2];
  bit   rsp_seen = 0;
  int   rsp_cyc = 0;
  int   grant_log [$];
  int   grant_cyc [$];

  function automatic int op_lat(input logic [OW-1:0] op);
    if (op == ALU_AND || op == ALU_OR || op == ALU_XOR) return 1;
    if (op == ALU_ARX) return 2;
    return 0;
  endfunction

  function automatic logic [47:0] f_res(input logic [OW-1:0] op, input logic [47:0] a, input logic [47:0] b);
    logic [48:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (op == ALU_AND) return a & b;
    if (op == ALU_OR)  return a | b;
    if (op == ALU_XOR) return a ^ b;
    if (op == ALU_ARX) return s[47:0] + {47'd0, s[48]};
    return '0;
  endfunction

  function automatic logic [47:0] f_y(input logic [OW-1:0] op, input logic [47:0] a);
    return (op == ALU_XOR) ? a : 48'd0;
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 60)
        $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic bm;
    int   gp;
    @(posedge clk);
    #1;
    cyc++;
    if (op_lat(s_op) == 0) begin
      alu_cnt    = 0;
      alu_done   = 1'b0;
      alu_result = 48'({$urandom, $urandom});
      alu_y      = 48'({$urandom, $urandom});
    end else begin
      alu_cnt++;
      if (alu_cnt >= op_lat(s_op)) begin
        alu_done   = 1'b1;
        alu_result = f_res(s_op, s_a, s_b);
        alu_y      = f_y(s_op, s_a);
      end else begin
        alu_done   = 1'b0;
        alu_result = 48'({$urandom, $urandom});
        alu_y      = 48'({$urandom, $urandom});
      end
    end
    reset     = drv_reset;
    req_valid = drv_reset ? 2'b00 : drv_valid;
    req_op    = drv_op;
    req_a     = drv_a;
    req_b     = drv_b;
    #1;
    if (chk_en) begin
      bm = m_has_op && (cyc < m_end);
      if (m_pend && cyc == m_rsp_cyc) begin
        chk("rsp_valid", 48'(rsp_valid), 48'd1);
        h_id = p_id; h_err = p_err; h_res = p_res; h_y = p_y;
        m_pend = 0;
      end else begin
        chk("rsp_valid", 48'(rsp_valid), 48'd0);
      end
      chk("rsp_id", 48'(rsp_id), 48'(h_id));
      chk("rsp_err", 48'(rsp_err), 48'(h_err));
      chk("rsp_result", rsp_result, h_res);
      chk("rsp_y", rsp_y, h_y);
      chk("busy", 48'(busy), 48'(bm));
      chk("alu_op", 48'(alu_op), 48'(bm ? m_op : ALU_NOP));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      gp = -1;
      if (!bm) begin
        if (req_valid == 2'b01) gp = 0;
        else if (req_valid == 2'b10) gp = 1;
        else if (req_valid == 2'b11) gp = m_last ? 0 : 1;
      end
      chk("req_ready", 48'(req_ready), (gp < 0) ? 48'd0 : (48'd1 << gp));
      if (gp >= 0) begin
        m_last = gp[0];
        if (req_op[gp] == ALU_NOP) begin
          m_pend = 1; m_rsp_cyc = cyc + 1;
          p_id = gp[0]; p_err = 0; p_res = '0; p_y = '0;
        end else begin
          m_has_op = 1;
          m_op = req_op[gp]; m_a = req_a[gp]; m_b = req_b[gp];
          m_pend = 1; p_id = gp[0];
          if (op_lat(m_op) != 0) begin
            m_end = cyc + op_lat(m_op) + 2;
            p_err = 0; p_res = f_res(m_op, m_a, m_b); p_y = f_y(m_op, m_a);
          end else begin
            m_end = cyc + T + 1;
            p_err = 1; p_res = '0; p_y = '0;
          end
          m_rsp_cyc = m_end;
        end
      end
    end
    if (drv_reset) begin
      m_has_op = 0; m_pend = 0; m_last = 1'b1; m_a = '0; m_b = '0; m_op = ALU_NOP;
      h_id = 0; h_err = 0; h_res = '0; h_y = '0;
      chk_en = 1;
    end
    for (int p = 0; p < 2; p++) begin
      if (req_valid[p] && req_ready[p]) begin
        drv_valid[p] = 1'b0;
        acc_seen[p]  = 1;
        acc_cyc[p]   = cyc;
        grant_log.push_back(p);
        grant_cyc.push_back(cyc);
      end
    end
    if (rsp_valid) begin
      rsp_seen = 1;
      rsp_cyc  = cyc;
    end
    s_op = alu_op; s_a = alu_a; s_b = alu_b;
  endtask

  task automatic run_req(input int p, input logic [OW-1:0] op, input logic [47:0] a, input logic [47:0] b,
                         input int lat, input logic [47:0] er, input logic [47:0] ey, input logic ee,
                         input string nm);
    int n;
    drv_op[p] = op; drv_a[p] = a; drv_b[p] = b; drv_valid[p] = 1'b1; acc_seen[p] = 0;
    n = 0;
    while (!acc_seen[p] && n < 50) begin step(); n++; end
    chk({nm, "_accepted"}, 48'(acc_seen[p]), 48'd1);
    rsp_seen = 0;
    n = 0;
    while (!rsp_seen && n < 50) begin step(); n++; end
    chk({nm, "_responded"}, 48'(rsp_seen), 48'd1);
    chk({nm, "_latency"}, 48'(rsp_cyc - acc_cyc[p]), 48'(lat));
    chk({nm, "_result"}, rsp_result, er);
    chk({nm, "_y"}, rsp_y, ey);
    chk({nm, "_err"}, 48'(rsp_err), 48'(ee));
    chk({nm, "_id"}, 48'(rsp_id), 48'(p));
  endtask

  function automatic logic [OW-1:0] rand_op();
    int r;
    r = int'($urandom_range(19));
    if (r < 3)  return ALU_NOP;
    if (r < 7)  return ALU_AND;
    if (r < 10) return ALU_OR;
    if (r < 14) return ALU_XOR;
    if (r < 18) return ALU_ARX;
    return ALU_FMUL;
  endfunction

  initial begin
    int n;
    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    alu_done = 1'b0; alu_result = '0; alu_y = '0;
    acc_seen[0] = 0; acc_seen[1] = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;

    drv_reset = 1'b1;
    step(); step();
    drv_reset = 1'b0;
    chk("reset_busy", 48'(busy), 48'd0);
    chk("reset_alu_op", 48'(alu_op), 48'(ALU_NOP));
    chk("reset_alu_a", alu_a, 48'd0);
    chk("reset_rsp_valid", 48'(rsp_valid), 48'd0);
    chk("reset_rsp_result", rsp_result, 48'd0);

    run_req(0, ALU_AND, 48'h0F0F, 48'h00FF, 3, 48'h000F, 48'h0, 1'b0, "and_p0");
    chk("and_alu_op_nop", 48'(alu_op), 48'(ALU_NOP));
    run_req(1, ALU_ARX, 48'hFFFF_FFFF_FFFF, 48'h1, 4, 48'h1, 48'h0, 1'b0, "arx_p1");

    // both ports streaming XOR: expect strict alternation every 3 cycles
    grant_log.delete(); grant_cyc.delete();
    n = 0;
    while (grant_log.size() < 6 && n < 60) begin
      for (int p = 0; p < 2; p++) begin
        if (!drv_valid[p]) begin
          drv_op[p] = ALU_XOR; drv_a[p] = 48'({$urandom, $urandom}); drv_b[p] = 48'({$urandom, $urandom});
          drv_valid[p] = 1'b1;
        end
      end
      step(); n++;
    end
    drv_valid = 2'b00;
    chk("alt_count", 48'(grant_log.size()), 48'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      chk("alt_port", 48'(grant_log[i]), 48'(i % 2));
      if (i > 0) chk("alt_spacing", 48'(grant_cyc[i] - grant_cyc[i-1]), 48'd3);
    end
    repeat (6) step();

    run_req(0, ALU_FMUL, 48'h1234, 48'h5678, T + 1, 48'h0, 48'h0, 1'b1, "fmul_timeout");
    run_req(1, ALU_XOR, 48'h5, 48'h3, 3, 48'h6, 48'h5, 1'b0, "xor_after_to");

    // reset in the second BUSY cycle of an ARX
    drv_op[0] = ALU_ARX; drv_a[0] = 48'h7; drv_b[0] = 48'h9; drv_valid[0] = 1'b1; acc_seen[0] = 0;
    n = 0;
    while (!acc_seen[0] && n < 50) begin step(); n++; end
    chk("rst_arx_accepted", 48'(acc_seen[0]), 48'd1);
    rsp_seen = 0;
    step();
    drv_reset = 1'b1; step();
    drv_reset = 1'b0; step();
    chk("rst_alu_op", 48'(alu_op), 48'(ALU_NOP));
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_rsp_result", rsp_result, 48'd0);
    repeat (5) step();
    chk("rst_no_rsp", 48'(rsp_seen), 48'd0);
    run_req(0, ALU_AND, 48'hF0F0, 48'hFF00, 3, 48'hF000, 48'h0, 1'b0, "and_after_rst");

    run_req(1, ALU_NOP, 48'hDEAD, 48'hBEEF, 1, 48'h0, 48'h0, 1'b0, "nop_p1");
    repeat (3) step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!drv_valid[p] && $urandom_range(2) == 0) begin
          drv_op[p] = rand_op();
          drv_a[p]  = ($urandom_range(3) == 0) ? 48'hFFFF_FFFF_FFFF : 48'({$urandom, $urandom});
          drv_b[p]  = 48'({$urandom, $urandom});
          drv_valid[p] = 1'b1;
        end
      end
      drv_reset = ($urandom_range(299) == 0);
      step();
    end
    drv_reset = 1'b0;
    drv_valid = 2'b00;
    repeat (T + 4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
